// File: rtl/status_serializer.sv
// ============================================================================
// status_serializer : MBED link transmitter, one status bit per tx_valid/tx_ack
// four-phase handshake, MSB first. Define PARITY_EN to append an even-parity bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module status_serializer #(
  parameter int WIDTH          = 10,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             send,
  input  logic [WIDTH-1:0] status_word,
  input  logic             tx_ack,
  output logic             tx_data,
  output logic             tx_valid,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam int PH_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [PH_W-1:0]  phase_cnt;
  logic             ack_meta, ack_s;
  logic             tx_data_n, tx_valid_n, busy_n, done_n, timeout_n;
  logic             timed_out;
`ifdef PARITY_EN
  logic             parity, parity_n;
`endif

  // Phase counter saturates one short of the limit; hitting that value aborts.
  assign timed_out = (phase_cnt == PH_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_meta    <= 1'b0;
      ack_s       <= 1'b0;
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      phase_cnt   <= '0;
      tx_data     <= 1'b0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
`ifdef PARITY_EN
      parity      <= 1'b0;
`endif
    end else begin
      ack_meta    <= tx_ack;
      ack_s       <= ack_meta;
      state       <= state_n;
      shreg       <= shreg_n;
      bit_cnt     <= bit_cnt_n;
      tx_data     <= tx_data_n;
      tx_valid    <= tx_valid_n;
      busy        <= busy_n;
      done        <= done_n;
      timeout_err <= timeout_n;
`ifdef PARITY_EN
      parity      <= parity_n;
`endif
      if (state_n != state)
        phase_cnt <= '0;
      else if (phase_cnt != PH_LAST)
        phase_cnt <= phase_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;
    busy_n     = busy;
    done_n     = 1'b0;
    timeout_n  = 1'b0;
`ifdef PARITY_EN
    parity_n   = parity;
`endif
    case (state)
      IDLE: begin
        if (send) begin
          shreg_n   = status_word;
          bit_cnt_n = '0;
          busy_n    = 1'b1;
          tx_data_n = status_word[WIDTH-1];
`ifdef PARITY_EN
          parity_n  = ^status_word;
`endif
          state_n   = SETUP;
        end
      end
      SETUP: begin
        if (!timed_out && !ack_s) begin
          tx_valid_n = 1'b1;
          state_n    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (!timed_out && ack_s) begin
          tx_valid_n = 1'b0;
          state_n    = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!timed_out && !ack_s) begin
          if (bit_cnt == LAST_BIT) begin
            done_n    = 1'b1;
            busy_n    = 1'b0;
            tx_data_n = 1'b0;
            state_n   = FINISH;
          end else begin
            shreg_n   = shreg << 1;
            bit_cnt_n = bit_cnt + 1'b1;
`ifdef PARITY_EN
            tx_data_n = (bit_cnt == CNT_W'(WIDTH - 1)) ? parity : shreg[WIDTH-2];
`else
            tx_data_n = shreg[WIDTH-2];
`endif
            state_n   = SETUP;
          end
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Abort overrides whatever the active phase decided.
    if (timed_out && (state == SETUP || state == WAIT_HI || state == WAIT_LO)) begin
      timeout_n  = 1'b1;
      tx_valid_n = 1'b0;
      tx_data_n  = 1'b0;
      busy_n     = 1'b0;
      state_n    = IDLE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_status_serializer.sv
// Testbench for status_serializer: random frames through a behavioural MBED
// responder, checked against the MSB-first (plus optional parity) bit list.
`default_nettype none

module tb_status_serializer;

  localparam int WIDTH = 10;
  localparam int TMO   = 16;
`ifdef PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             send = 1'b0;
  logic [WIDTH-1:0] status_word = '0;
  logic             tx_ack = 1'b0;
  logic             tx_data, tx_valid, busy, done, timeout_err;

  status_serializer #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .send(send), .status_word(status_word), .tx_ack(tx_ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // MBED responder: mode 0 forces tx_ack, mode 1 mirrors tx_valid after a delay.
  int mbed_mode = 0;
  bit ack_force = 1'b0;
  int fixed_dly = 3;
  int dly = 3;
  int dly_cnt = 0;
  always begin
    @(negedge clk); #1;
    if (mbed_mode == 0) begin
      tx_ack  = ack_force;
      dly_cnt = 0;
    end else if (tx_valid != tx_ack) begin
      if (dly_cnt >= dly) begin
        tx_ack  = tx_valid;
        dly_cnt = 0;
        dly     = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 5));
      end else begin
        dly_cnt++;
      end
    end else begin
      dly_cnt = 0;
    end
  end

  // Monitor: captures tx_data on each strobe rise and counts pulses.
  bit   cap_q[$];
  int   done_cnt = 0, done_hi = 0, to_cnt = 0, to_hi = 0;
  int   run = 0, last_run = 0, unstable = 0;
  logic prev_valid = 1'b0, prev_done = 1'b0, prev_to = 1'b0, held = 1'b0;
  always begin
    @(posedge clk); #1;
    if (tx_valid && !prev_valid) begin
      cap_q.push_back(tx_data);
      held = tx_data;
      run  = 1;
    end else if (tx_valid) begin
      run++;
      if (tx_data !== held) unstable++;
    end
    if (!tx_valid && prev_valid) last_run = run;
    if (done) begin done_hi++; if (!prev_done) done_cnt++; end
    if (timeout_err) begin to_hi++; if (!prev_to) to_cnt++; end
    prev_valid = tx_valid;
    prev_done  = done;
    prev_to    = timeout_err;
  end

  int s_start, s_done, s_dhi, s_to, s_unst;
  task automatic snapshot();
    s_start = cap_q.size();
    s_done  = done_cnt;
    s_dhi   = done_hi;
    s_to    = to_cnt;
    s_unst  = unstable;
  endtask

  task automatic start_frame(input logic [WIDTH-1:0] word);
    @(negedge clk);
    snapshot();
    send        = 1'b1;
    status_word = word;
    @(negedge clk);
    send        = 1'b0;
    status_word = WIDTH'($urandom);
  endtask

  task automatic finish_frame(input logic [WIDTH-1:0] word, input bit inject);
    bit got_end = 1'b0;
    bit injected = 1'b0;
    bit e;
    for (int c = 0; c < 2000 && !got_end; c++) begin
      @(negedge clk);
      if (inject && !injected && cap_q.size() == s_start + 3) begin
        send        = 1'b1;
        status_word = '0;
        injected    = 1'b1;
      end else begin
        send = 1'b0;
      end
      if (done_cnt != s_done || to_cnt != s_to) got_end = 1'b1;
    end
    send = 1'b0;
    check("frame_end_seen", int'(got_end), 1);
    check("done_count", done_cnt - s_done, 1);
    check("no_timeout", to_cnt - s_to, 0);
    check("busy_low_at_done", int'(busy), 0);
    check("frame_len", cap_q.size() - s_start, FRAME);
    for (int i = 0; i < FRAME; i++) begin
      e = (i < WIDTH) ? word[WIDTH-1-i] : ^word;
      if (s_start + i < cap_q.size())
        check($sformatf("bit%0d", i), int'(cap_q[s_start+i]), int'(e));
    end
    check("data_stable", unstable - s_unst, 0);
    @(negedge clk);
    check("done_one_cycle", done_hi - s_dhi, 1);
    check("idle_after", int'({busy, tx_valid, tx_data, done}), 0);
  endtask

  task automatic run_frame(input logic [WIDTH-1:0] word, input bit inject);
    start_frame(word);
    check("busy_next_cycle", int'(busy), 1);
    check("msb_first", int'(tx_data), int'(word[WIDTH-1]));
    check("strobe_after_data", int'(tx_valid), 0);
    finish_frame(word, inject);
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    bit got;
    bit any_v;

    repeat (3) @(negedge clk);
    check("reset_outputs", int'({tx_data, tx_valid, busy, done, timeout_err}), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", int'({tx_data, tx_valid, busy, done, timeout_err}), 0);

    mbed_mode = 1;
    fixed_dly = 3;
    dly       = 3;
    run_frame(10'b10_1100_0011, 1'b0);

    fixed_dly = -1;
    for (int k = 0; k < 20; k++) run_frame(WIDTH'($urandom), 1'b0);
    run_frame(10'h3FF, 1'b0);
    run_frame(10'h000, 1'b0);
    run_frame(10'b00_0000_0111, 1'b0);
    run_frame(10'b00_0000_0011, 1'b0);

    // send pulsed mid-frame must be ignored
    run_frame(10'h2AA, 1'b1);

    // MBED never acknowledges
    mbed_mode = 0;
    ack_force = 1'b0;
    start_frame(WIDTH'($urandom));
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (to_cnt != s_to) got = 1'b1;
    end
    check("timeout_seen", int'(got), 1);
    check("timeout_strobe_len", last_run, TMO);
    check("timeout_err_high", int'(timeout_err), 1);
    check("abort_outputs", int'({tx_valid, tx_data, busy, done}), 0);
    check("timeout_no_done", done_cnt - s_done, 0);
    @(negedge clk);
    check("timeout_one_cycle", to_hi - 0, to_cnt);
    check("timeout_err_cleared", int'(timeout_err), 0);
    mbed_mode = 1;
    run_frame(WIDTH'($urandom), 1'b0);

    // Stale acknowledge held high at send
    mbed_mode = 0;
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    w = WIDTH'($urandom);
    start_frame(w);
    any_v = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      any_v |= tx_valid;
    end
    check("stale_hold", int'(any_v), 0);
    ack_force = 1'b0;
    @(negedge clk);
    check("stale_sync1", int'(tx_valid), 0);
    @(negedge clk);
    check("stale_sync2", int'(tx_valid), 0);
    @(negedge clk);
    check("stale_release", int'(tx_valid), 1);
    mbed_mode = 1;
    finish_frame(w, 1'b0);

    // Reset while the fourth bit is strobed
    fixed_dly = 3;
    dly       = 3;
    start_frame(WIDTH'($urandom));
    got = 1'b0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      if (cap_q.size() >= s_start + 4 && tx_valid) got = 1'b1;
    end
    check("bit4_reached", int'(got), 1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", int'({tx_valid, tx_data, busy}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_no_done", done_cnt - s_done, 0);
    check("reset_no_timeout", to_cnt - s_to, 0);
    run_frame(10'h3FF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
